// File: rtl/packet_rr_arbiter_if.sv
// Shared widths and the packet-stream bundle used on both sides of the arbiter.
package packet_mux_pkg;
  localparam int unsigned DATA_W  = 64;
  localparam int unsigned EMPTY_W = 3;
endpackage

// N parallel packet streams; the arbiter input uses N=N_IN, its output N=1.
interface packet_rr_arbiter_if #(
  parameter int unsigned N      = 1,
  parameter int unsigned DATA_W = packet_mux_pkg::DATA_W,
  parameter int unsigned EMP_W  = packet_mux_pkg::EMPTY_W
);
  logic [N*DATA_W-1:0] data;
  logic [N-1:0]        valid;
  logic [N-1:0]        sop;
  logic [N-1:0]        eop;
  logic [N*EMP_W-1:0]  empty;
  logic [N-1:0]        error;
  logic [N-1:0]        ready;

  modport master (output data, valid, sop, eop, empty, error, input ready);
  modport slave  (input data, valid, sop, eop, empty, error, output ready);
endinterface

// File: rtl/packet_rr_arbiter.sv
// Packet-aware round-robin merge of N_IN streams into one; packets are never
// interleaved and beats arriving outside a packet are flushed and counted.
module packet_rr_arbiter #(
  parameter int unsigned DATA_W = packet_mux_pkg::DATA_W,
  parameter int unsigned EMP_W  = packet_mux_pkg::EMPTY_W,
  parameter int unsigned N_IN   = 2,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  packet_rr_arbiter_if.slave        s,
  packet_rr_arbiter_if.master       m,
  output logic [$clog2(N_IN)-1:0]   grant_idx,
  output logic                      busy,
  output logic [CNT_W-1:0]          drop_cnt
);
  localparam int unsigned IDX_W = $clog2(N_IN);
  localparam int unsigned SUM_W = CNT_W + 4;
  localparam logic [SUM_W-1:0] CNT_MAX = {4'b0, {CNT_W{1'b1}}};

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t            state;
  logic [IDX_W-1:0]  last_grant;
  logic              mid_pkt;
  logic [N_IN-1:0]   req;
  logic [N_IN-1:0]   orphan;
  logic              any_req;
  logic [IDX_W-1:0]  winner;
  int unsigned       rr_idx;
  logic [3:0]        orphan_n;
  logic [SUM_W-1:0]  drop_sum;
  logic              accept;

  assign req    = s.valid & s.sop;
  assign orphan = s.valid & ~s.sop;
  assign busy   = (state == LOCKED);
  assign accept = (state == LOCKED) && s.valid[grant_idx] && m.ready[0];

  // Round-robin pick: first request at or after last_grant+1, wrapping.
  always_comb begin
    any_req = 1'b0;
    winner  = '0;
    rr_idx  = 0;
    for (int unsigned k = 1; k <= N_IN; k++) begin
      rr_idx = (32'(last_grant) + k) % N_IN;
      if (!any_req && req[rr_idx[IDX_W-1:0]]) begin
        any_req = 1'b1;
        winner  = rr_idx[IDX_W-1:0];
      end
    end
  end

  // Orphans flushed this cycle and the saturating drop total they produce.
  always_comb begin
    orphan_n = '0;
    for (int unsigned i = 0; i < N_IN; i++) begin
      orphan_n = orphan_n + 4'(orphan[i]);
    end
    drop_sum = SUM_W'(drop_cnt) + SUM_W'(orphan_n);
  end

  // Zero-latency pass-through of the locked input; ready gated off while in reset.
  always_comb begin
    s.ready = '0;
    m.data  = '0;
    m.valid = '0;
    m.sop   = '0;
    m.eop   = '0;
    m.empty = '0;
    m.error = '0;
    if (rst_n) begin
      if (state == LOCKED) begin
        m.data     = s.data[32'(grant_idx)*DATA_W +: DATA_W];
        m.valid[0] = s.valid[grant_idx];
        m.sop[0]   = s.sop[grant_idx];
        m.eop[0]   = s.eop[grant_idx];
        m.empty    = s.empty[32'(grant_idx)*EMP_W +: EMP_W];
        // A sop after the first beat means the previous eop went missing.
        m.error[0] = s.error[grant_idx] | (s.sop[grant_idx] & mid_pkt);
        s.ready[grant_idx] = m.ready[0];
      end else begin
        s.ready = orphan;
      end
    end
  end

  // Arbitration FSM, grant bookkeeping and drop counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= IDX_W'(N_IN - 1);
      grant_idx  <= '0;
      drop_cnt   <= '0;
      mid_pkt    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (drop_sum > CNT_MAX) drop_cnt <= '1;
          else                    drop_cnt <= CNT_W'(drop_sum);
          if (any_req) begin
            state     <= LOCKED;
            grant_idx <= winner;
            mid_pkt   <= 1'b0;
          end
        end
        LOCKED: begin
          if (accept) begin
            mid_pkt <= 1'b1;
            if (s.eop[grant_idx]) begin
              state      <= IDLE;
              last_grant <= grant_idx;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/packet_rr_arbiter.md
Name: packet_rr_arbiter

Overview:
- Packet-aware round-robin arbiter that merges N_IN packet streams into one output stream.
- The output feeds the downstream skid buffer's slave interface.
- Once a packet is granted, it is forwarded whole, sop through eop, with no interleaving.
- Beats that arrive outside any packet are flushed and counted.

Parameters:
- DATA_W, 64, beat data width (packet_mux_pkg::DATA_W).
- EMP_W, 3, empty-byte field width (packet_mux_pkg::EMPTY_W).
- N_IN, 2, number of input streams (2..8).
- CNT_W, 16, drop counter width.

Ports:
- clk  in  1  single clock
- rst_n  in  1  reset, asynchronous assert, active-low
- s_data  in  N_IN*DATA_W  per-input data, input i at [i*DATA_W +: DATA_W]
- s_valid  in  N_IN  per-input valid
- s_sop  in  N_IN  per-input start of packet
- s_eop  in  N_IN  per-input end of packet
- s_empty  in  N_IN*EMP_W  per-input empty count
- s_error  in  N_IN  per-input error
- s_ready  out  N_IN  per-input ready
- m_data  out  DATA_W  output data
- m_valid  out  1  output valid
- m_sop  out  1  output start of packet
- m_eop  out  1  output end of packet
- m_empty  out  EMP_W  output empty count
- m_error  out  1  output error
- m_ready  in  1  downstream ready (skid buffer s_ready)
- grant_idx  out  $clog2(N_IN)  index of the currently locked input
- busy  out  1  1 while in state LOCKED
- drop_cnt  out  CNT_W  saturating count of flushed orphan beats

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, last_grant=N_IN-1, grant_idx=0, drop_cnt=0.
  - m_valid=0, s_ready=0, busy=0.
  - m_data/sop/eop/empty/error = 0.
- State IDLE:
  - m_valid=0.
  - Request vector req[i] = s_valid[i] & s_sop[i].
  - Round-robin search starts at (last_grant+1) mod N_IN and takes the first set req.
  - If any req is set: next cycle state=LOCKED, grant_idx=winner, busy=1. No beat is consumed in IDLE, so there is a 1-cycle arbitration bubble per packet.
  - Orphan flush: for each i with s_valid[i] & !s_sop[i], s_ready[i]=1 and the beat is discarded.
  - drop_cnt increments by the number of orphans flushed that cycle, saturating at all-ones.
  - All other s_ready in IDLE are 0.
- State LOCKED (g=grant_idx):
  - m_* is combinational from input g; m_valid = s_valid[g].
  - s_ready[g] = m_ready; all other s_ready = 0.
  - Zero-latency pass-through, so m_valid may depend combinationally on s_valid.
  - Beat accepted when s_valid[g] & m_ready.
  - Accepted beat with s_eop[g]=1: next cycle state=IDLE, last_grant=g, busy=0.
  - Single-beat packet (sop & eop on one beat) is legal: forwarded, then back to IDLE.
  - Accepted beat with s_sop=1 after the first beat (missing eop): forwarded unchanged with m_error forced to 1. Lock is held until an eop is accepted.
  - m_ready=0 holds all state. Output signals stay stable while m_valid=1 as long as the source holds them (AXI/Avalon-ST rule).
- Fairness:
  - last_grant updates only on packet completion.
  - An input that has just completed a packet has the lowest priority at the next arbitration.
  - With all inputs continuously requesting, packets alternate 0,1,...,N_IN-1,0.
- grant_idx holds its last value while in IDLE.
- drop_cnt never wraps.
- Reset mid-packet: everything returns to the reset values immediately. The partial packet is not completed; downstream sees m_valid drop.

Test Plan:
- Single source:
  - Stimulus: input 0 sends a 4-beat packet (sop on beat 0, eop with empty=3 on beat 3), m_ready=1.
  - Response: m_valid=0 for 1 cycle, then 4 consecutive beats with identical data/empty. busy falls the cycle after eop. drop_cnt=0.
- Contention:
  - Stimulus: inputs 0 and 1 each present three 2-beat packets back-to-back from reset.
  - Response: output packet order 0,1,0,1,0,1. No beat interleaving. s_ready[1]=0 throughout input 0's packets.
- Backpressure:
  - Stimulus: while LOCKED on input 1, m_ready=0 for 5 cycles mid-packet.
  - Response: m_data/m_valid stable, s_ready[1]=0, state held. The packet resumes intact when m_ready returns to 1.
- Orphans:
  - Stimulus: in IDLE, input 1 presents 3 valid beats with sop=0.
  - Response: all 3 are accepted and dropped, nothing appears on m_*, drop_cnt=3.
  - Stimulus: with CNT_W=2, present 5 orphans.
  - Response: drop_cnt saturates at 3.
- Missing eop:
  - Stimulus: input 0 sends sop, data, then a second sop.
  - Response: the third beat is output with m_error=1 and the lock is held. After an eop is accepted, state returns to IDLE.
- Async reset:
  - Stimulus: assert rst_n=0 on beat 2 of 4.
  - Response: m_valid=0, s_ready=0, busy=0 immediately (not waiting for clk). After release, arbitration restarts from input 0.
